// File: rtl/uart_wishbone_bridge.sv
// uart_wishbone_bridge: decodes a UART byte-stream command protocol and acts as a
// Wishbone B4 classic bus master. Read data is returned MSB first as a byte stream.
module uart_wishbone_bridge #(
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RX_TIMEOUT = 1000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    wb_cyc,
    output logic                    wb_stb,
    output logic                    wb_we,
    output logic [ADDR_WIDTH-1:0]   wb_adr,
    output logic [DATA_WIDTH-1:0]   wb_dat_w,
    output logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0]   wb_dat_r,
    input  logic                    wb_ack,
    input  logic                    wb_err,
    output logic                    busy,
    output logic                    frame_error,
    output logic                    bus_error
);

    localparam int unsigned NB  = DATA_WIDTH / 8;
    localparam int unsigned BCW = $clog2((NB > 4) ? NB : 4) + 1;
    localparam int unsigned TW  = $clog2(RX_TIMEOUT + 1);

    localparam logic [BCW-1:0] LAST_ADR_BYTE = BCW'(3);
    localparam logic [BCW-1:0] LAST_DAT_BYTE = BCW'(NB - 1);
    localparam logic [TW-1:0]  TIMER_MAX     = TW'(RX_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StAddr,
        StWdata,
        StWbWr,
        StWbRd,
        StTx
    } state_e;

    state_e                  state_q;
    logic                    cmd_read_q;
    logic                    cmd_fixed_q;
    logic [8:0]              len_q;
    logic [8:0]              word_cnt_q;
    logic [BCW-1:0]          byte_cnt_q;
    logic [TW-1:0]           timer_q;
    logic [DATA_WIDTH-1:0]   rd_shift_q;

    logic                    timing;
    logic                    last_word;
    logic [ADDR_WIDTH-1:0]   next_adr;

    assign rx_ready  = (state_q == StIdle) || (state_q == StLen) ||
                       (state_q == StAddr) || (state_q == StWdata);
    assign timing    = (state_q == StLen) || (state_q == StAddr) || (state_q == StWdata);
    assign busy      = (state_q != StIdle);
    assign wb_sel    = '1;
    assign tx_data   = rd_shift_q[DATA_WIDTH-1 -: 8];
    assign last_word = (9'(word_cnt_q + 9'd1) == len_q);
    assign next_adr  = cmd_fixed_q ? wb_adr : ADDR_WIDTH'(wb_adr + ADDR_WIDTH'(1));

    // Frame decoder, bus master and transmit sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cmd_read_q  <= 1'b0;
            cmd_fixed_q <= 1'b0;
            len_q       <= '0;
            word_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            timer_q     <= '0;
            rd_shift_q  <= '0;
            tx_valid    <= 1'b0;
            wb_cyc      <= 1'b0;
            wb_stb      <= 1'b0;
            wb_we       <= 1'b0;
            wb_adr      <= '0;
            wb_dat_w    <= '0;
            frame_error <= 1'b0;
            bus_error   <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            bus_error   <= 1'b0;

            // Inter-byte timer: cleared by every accepted byte, aborts the frame on expiry.
            if (timing) begin
                if (rx_valid) begin
                    timer_q <= '0;
                end else if (timer_q == TIMER_MAX) begin
                    timer_q     <= '0;
                    frame_error <= 1'b1;
                    state_q     <= StIdle;
                end else begin
                    timer_q <= timer_q + TW'(1);
                end
            end

            unique case (state_q)
                StIdle: begin
                    // Unknown command bytes are swallowed silently.
                    if (rx_valid && rx_data >= 8'h01 && rx_data <= 8'h04) begin
                        cmd_read_q  <= ~rx_data[0];
                        cmd_fixed_q <= (rx_data >= 8'h03);
                        timer_q     <= '0;
                        state_q     <= StLen;
                    end
                end
                StLen: begin
                    if (rx_valid) begin
                        len_q      <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        byte_cnt_q <= '0;
                        state_q    <= StAddr;
                    end
                end
                StAddr: begin
                    if (rx_valid) begin
                        // Shifting 4 bytes through keeps only the low ADDR_WIDTH bits.
                        wb_adr <= ADDR_WIDTH'({wb_adr, rx_data});
                        if (byte_cnt_q == LAST_ADR_BYTE) begin
                            byte_cnt_q <= '0;
                            word_cnt_q <= '0;
                            if (cmd_read_q) begin
                                wb_cyc  <= 1'b1;
                                wb_stb  <= 1'b1;
                                wb_we   <= 1'b0;
                                state_q <= StWbRd;
                            end else begin
                                state_q <= StWdata;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end
                end
                StWdata: begin
                    if (rx_valid) begin
                        wb_dat_w <= DATA_WIDTH'({wb_dat_w, rx_data});
                        if (byte_cnt_q == LAST_DAT_BYTE) begin
                            byte_cnt_q <= '0;
                            wb_cyc     <= 1'b1;
                            wb_stb     <= 1'b1;
                            wb_we      <= 1'b1;
                            state_q    <= StWbWr;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end
                end
                StWbWr: begin
                    if (wb_ack || wb_err) begin
                        wb_cyc     <= 1'b0;
                        wb_stb     <= 1'b0;
                        wb_we      <= 1'b0;
                        bus_error  <= wb_err;
                        wb_adr     <= next_adr;
                        word_cnt_q <= word_cnt_q + 9'd1;
                        timer_q    <= '0;
                        state_q    <= last_word ? StIdle : StWdata;
                    end
                end
                StWbRd: begin
                    if (wb_ack || wb_err) begin
                        wb_cyc     <= 1'b0;
                        wb_stb     <= 1'b0;
                        bus_error  <= wb_err;
                        // An error beats a simultaneous ack and returns all-ones.
                        rd_shift_q <= wb_err ? '1 : wb_dat_r;
                        tx_valid   <= 1'b1;
                        byte_cnt_q <= '0;
                        state_q    <= StTx;
                    end
                end
                StTx: begin
                    if (tx_ready) begin
                        if (byte_cnt_q == LAST_DAT_BYTE) begin
                            tx_valid   <= 1'b0;
                            byte_cnt_q <= '0;
                            wb_adr     <= next_adr;
                            word_cnt_q <= word_cnt_q + 9'd1;
                            if (last_word) begin
                                state_q <= StIdle;
                            end else begin
                                wb_cyc  <= 1'b1;
                                wb_stb  <= 1'b1;
                                state_q <= StWbRd;
                            end
                        end else begin
                            rd_shift_q <= rd_shift_q << 8;
                            byte_cnt_q <= byte_cnt_q + BCW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_wishbone_bridge.sv
// tb_uart_wishbone_bridge: randomized frames against a transaction-level reference model.
module tb_uart_wishbone_bridge;

    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned NB = DW / 8;
    localparam int unsigned TO = 64;
    localparam logic [31:0] MASK = 32'h3FFF_FFFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_adr;
    logic [DW-1:0] wb_dat_w;
    logic [NB-1:0] wb_sel;
    logic [DW-1:0] wb_dat_r;
    logic          wb_ack, wb_err;
    logic          busy, frame_error, bus_error;

    uart_wishbone_bridge #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RX_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .wb_cyc     (wb_cyc),
        .wb_stb     (wb_stb),
        .wb_we      (wb_we),
        .wb_adr     (wb_adr),
        .wb_dat_w   (wb_dat_w),
        .wb_sel     (wb_sel),
        .wb_dat_r   (wb_dat_r),
        .wb_ack     (wb_ack),
        .wb_err     (wb_err),
        .busy       (busy),
        .frame_error(frame_error),
        .bus_error  (bus_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stimulus/response state shared with the slave and sink processes.
    logic [31:0] wq[$];
    logic        rsp_err[$];
    logic [31:0] rsp_dat[$];
    logic        obs_we[$];
    logic [31:0] obs_adr[$];
    logic [31:0] obs_dat[$];
    logic [7:0]  tx_got[$];
    int          be_cnt = 0;
    int          fe_cnt = 0;
    int          hold_req = 0;
    bit          slave_stall = 0;

    // Wishbone slave: random wait states, scripted ack/err responses, transaction log.
    initial begin
        bit          in_txn;
        bit          drop_chk;
        int          delay;
        logic        e;
        logic [31:0] d;
        in_txn = 0; drop_chk = 0; delay = 0;
        wb_ack = 0; wb_err = 0; wb_dat_r = '0;
        forever begin
            @(negedge clk);
            wb_ack = 0; wb_err = 0; wb_dat_r = '0;
            if (drop_chk) begin
                check_eq("cyc_drop", {63'd0, wb_cyc}, 64'd0);
                drop_chk = 0;
            end
            if (!rst_n) begin
                in_txn = 0;
            end else if (wb_cyc && wb_stb) begin
                if (!in_txn) begin
                    in_txn = 1;
                    delay = $urandom_range(0, 2);
                    check_eq("wb_sel", {60'd0, wb_sel}, 64'hF);
                end
                if (delay > 0) begin
                    delay--;
                end else if (!slave_stall) begin
                    if (rsp_err.size() > 0) begin
                        e = rsp_err.pop_front();
                        d = rsp_dat.pop_front();
                    end else begin
                        e = 0; d = '0;
                    end
                    obs_we.push_back(wb_we);
                    obs_adr.push_back({2'b00, wb_adr});
                    obs_dat.push_back(wb_we ? wb_dat_w : 32'd0);
                    if (e) begin
                        wb_err = 1;
                        wb_ack = ($urandom_range(0, 1) == 1);
                        wb_dat_r = $urandom;
                    end else begin
                        wb_ack = 1;
                        wb_dat_r = d;
                    end
                    in_txn = 0;
                    drop_chk = 1;
                end
            end
        end
    end

    // Transmit sink: random back-pressure, optional forced stall mid-word, hold checks.
    initial begin
        bit         stall_chk;
        logic [7:0] held;
        stall_chk = 0; held = '0;
        tx_ready = 0;
        forever begin
            @(negedge clk);
            if (stall_chk) begin
                check_eq("tx_valid_hold", {63'd0, tx_valid}, 64'd1);
                check_eq("tx_data_hold", {56'd0, tx_data}, {56'd0, held});
                stall_chk = 0;
            end
            if (!rst_n) begin
                tx_ready = 0;
            end else begin
                if (tx_valid && hold_req > 0 && (tx_got.size() % NB) == 1) begin
                    tx_ready = 0;
                    hold_req--;
                end else begin
                    tx_ready = ($urandom_range(0, 3) != 0);
                end
                if (tx_valid) begin
                    if (tx_ready) tx_got.push_back(tx_data);
                    else begin
                        stall_chk = 1;
                        held = tx_data;
                    end
                end
            end
        end
    end

    // Pulse counters for the error strobes.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_error) be_cnt++;
            if (frame_error) fe_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        @(negedge clk);
        rx_data = b;
        rx_valid = 1;
        guard = 0;
        while (!rx_ready && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) check_eq("rx_ready_wait", {63'd0, rx_ready}, 64'd1);
        @(posedge clk);
        #1 rx_valid = 0;
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (busy && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        check_eq(tag, {63'd0, busy}, 64'd0);
    endtask

    // Builds the frame, predicts bus transactions and returned bytes, runs and compares.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] len_b,
                             input logic [31:0] adr);
        int          n;
        int          nerr;
        bit          is_wr;
        bit          fixed;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_we[$];
        logic [31:0] exp_adr[$];
        logic [31:0] exp_dat[$];
        logic [7:0]  exp_tx[$];
        logic [7:0]  bytes[$];
        n = (len_b == 8'd0) ? 256 : int'(len_b);
        is_wr = (cmd == 8'h01) || (cmd == 8'h03);
        fixed = (cmd == 8'h03) || (cmd == 8'h04);
        while (wq.size() < n) wq.push_back($urandom);
        while (rsp_err.size() < n) begin
            rsp_err.push_back($urandom_range(0, 4) == 0);
            rsp_dat.push_back($urandom);
        end
        nerr = 0;
        for (int i = 0; i < n; i++) begin
            a = fixed ? (adr & MASK) : (((adr & MASK) + i) & MASK);
            exp_we.push_back(is_wr);
            exp_adr.push_back(a);
            exp_dat.push_back(is_wr ? wq[i] : 32'd0);
            if (rsp_err[i]) nerr++;
            if (!is_wr) begin
                d = rsp_err[i] ? 32'hFFFF_FFFF : rsp_dat[i];
                for (int k = 3; k >= 0; k--) exp_tx.push_back(d[k*8 +: 8]);
            end
        end
        bytes.push_back(cmd);
        bytes.push_back(len_b);
        for (int k = 3; k >= 0; k--) bytes.push_back(adr[k*8 +: 8]);
        if (is_wr) begin
            for (int i = 0; i < n; i++) begin
                for (int k = 3; k >= 0; k--) bytes.push_back(wq[i][k*8 +: 8]);
            end
        end
        wq.delete();
        obs_we.delete(); obs_adr.delete(); obs_dat.delete(); tx_got.delete();
        be_cnt = 0;
        foreach (bytes[i]) begin
            send_byte(bytes[i]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle("frame_done");
        @(negedge clk);
        check_eq("txn_count", obs_adr.size(), exp_adr.size());
        for (int i = 0; i < n && i < obs_adr.size(); i++) begin
            check_eq($sformatf("we[%0d]", i), {63'd0, obs_we[i]}, {63'd0, exp_we[i]});
            check_eq($sformatf("adr[%0d]", i), obs_adr[i], exp_adr[i]);
            check_eq($sformatf("dat_w[%0d]", i), obs_dat[i], exp_dat[i]);
        end
        check_eq("tx_count", tx_got.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++)
            check_eq($sformatf("tx[%0d]", i), {56'd0, tx_got[i]}, {56'd0, exp_tx[i]});
        check_eq("bus_error_pulses", be_cnt, nerr);
        rsp_err.delete(); rsp_dat.delete();
    endtask

    initial begin
        logic [7:0] junk;
        repeat (3) @(negedge clk);
        check_eq("rst_rx_ready", {63'd0, rx_ready}, 64'd1);
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_cyc_stb_we", {61'd0, wb_cyc, wb_stb, wb_we}, 64'd0);
        check_eq("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check_eq("rst_pulses", {62'd0, frame_error, bus_error}, 64'd0);
        check_eq("rst_adr", {34'd0, wb_adr}, 64'd0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Legacy single-word write.
        wq.push_back(32'h0000_000E);
        rsp_err.push_back(0); rsp_dat.push_back(32'd0);
        run_frame(8'h01, 8'h01, 32'h0000_2400);

        // Two-word incrementing read with known data.
        rsp_err.push_back(0); rsp_dat.push_back(32'h1234_5678);
        rsp_err.push_back(0); rsp_dat.push_back(32'h9ABC_DEF0);
        run_frame(8'h02, 8'h02, 32'h0400_0000);

        // Fixed-address write burst.
        run_frame(8'h03, 8'h03, 32'h0000_0010);

        // Truncated frame times out: one-cycle frame_error, no bus traffic.
        obs_adr.delete();
        fe_cnt = 0;
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
        repeat (TO - 5) @(negedge clk);
        check_eq("timeout_early", fe_cnt, 0);
        check_eq("timeout_busy_pre", {63'd0, busy}, 64'd1);
        repeat (25) @(negedge clk);
        check_eq("timeout_pulse", fe_cnt, 1);
        check_eq("timeout_no_bus", obs_adr.size(), 0);
        check_eq("timeout_idle", {63'd0, busy}, 64'd0);
        run_frame(8'h01, 8'h02, 32'h0000_0100);

        // Erroring read with a forced mid-word transmit stall.
        rsp_err.push_back(1); rsp_dat.push_back(32'h5555_AAAA);
        hold_req = 10;
        run_frame(8'h02, 8'h01, 32'h0000_0020);
        check_eq("hold_consumed", hold_req, 0);

        // Address wraps at 2^ADDR_WIDTH.
        run_frame(8'h02, 8'h02, 32'h3FFF_FFFF);

        // Randomized frames, with ignored garbage bytes in between.
        for (int f = 0; f < 12; f++) begin
            junk = 8'h05 + 8'($urandom_range(0, 200));
            send_byte(junk);
            check_eq("junk_ignored", {63'd0, busy}, 64'd0);
            run_frame(8'($urandom_range(1, 4)), 8'($urandom_range(1, 5)), $urandom);
        end

        // LEN=0 means 256 words.
        run_frame(8'h03, 8'h00, $urandom);

        // Asynchronous reset while a write strobe is outstanding.
        slave_stall = 1;
        send_byte(8'h01); send_byte(8'h01);
        for (int k = 0; k < 4; k++) send_byte(8'h00);
        for (int k = 0; k < 4; k++) send_byte(8'($urandom));
        begin
            int guard;
            guard = 0;
            while (!wb_stb && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            check_eq("stb_seen", {63'd0, wb_stb}, 64'd1);
        end
        @(negedge clk);
        rst_n = 0;
        #1;
        check_eq("async_rst_cyc", {62'd0, wb_cyc, wb_stb}, 64'd0);
        check_eq("async_rst_rx_ready", {63'd0, rx_ready}, 64'd1);
        check_eq("async_rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1;
        slave_stall = 0;
        rsp_err.delete(); rsp_dat.delete();
        repeat (2) @(negedge clk);
        run_frame(8'h02, 8'h01, 32'h0000_0042);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
